// File: rtl/paralelo_serial_tx_if.sv
// paralelo_serial_tx_if: byte handshake into the serializer and serial stream/status out
interface paralelo_serial_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       byte_start;
    logic       data_valid_out;
    logic       active;
    modport master (output data_in, valid_in, input ready_out, data_out, byte_start, data_valid_out, active);
    modport slave  (input data_in, valid_in, output ready_out, data_out, byte_start, data_valid_out, active);
endinterface

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: one-byte buffered parallel-to-serial transmitter, MSB first, with post-reset idle sync
module paralelo_serial_tx #(
    parameter logic [7:0] IDLE_SYM   = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input logic clk_32f,
    input logic reset,
    paralelo_serial_tx_if.slave bus
);
    typedef enum logic {SYNC, ACTIVE} state_t;
    state_t state, state_nx;
    logic [7:0] sreg, hold;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt;
    logic buf_full, is_data, boundary, load_buf, accept, ready;
    always_comb begin
        boundary = bit_cnt == 3'd7;
        load_buf = boundary & (state == ACTIVE) & buf_full;
        ready    = (state == ACTIVE) & ~buf_full;
        accept   = bus.valid_in & ready;
        state_nx = (state == SYNC && boundary && sync_cnt == 4'(SYNC_COUNT - 1)) ? ACTIVE : state;
    end
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) state <= SYNC;
        else state <= state_nx;
    end
    // bit_cnt wraps 7 -> 0 on its own, which is exactly the boundary reload
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sreg     <= '0;
            bit_cnt  <= 3'd7;
            hold     <= '0;
            buf_full <= 1'b0;
            sync_cnt <= '0;
            is_data  <= 1'b0;
        end else begin
            sreg     <= boundary ? (load_buf ? hold : IDLE_SYM) : {sreg[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 3'd1;
            buf_full <= accept | (buf_full & ~load_buf);
            if (boundary) is_data <= load_buf;
            if (boundary && state == SYNC) sync_cnt <= sync_cnt + 4'd1;
            if (accept) hold <= bus.data_in;
        end
    end
    assign bus.data_out       = sreg[7];
    assign bus.ready_out      = ready;
    assign bus.byte_start     = (bit_cnt == 3'd0) & (state == ACTIVE || sync_cnt != 4'd0);
    assign bus.data_valid_out = is_data;
    assign bus.active         = state == ACTIVE;
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: random handshake traffic and async resets on two configurations, checked per cycle
module tb_paralelo_serial_tx;
    localparam logic [7:0] IDLE = 8'hBC;
    logic clk_32f = 1'b0;
    logic reset = 1'b1;
    always #5 clk_32f = ~clk_32f;
    paralelo_serial_tx_if b0 ();
    paralelo_serial_tx_if b1 ();
    paralelo_serial_tx #(.IDLE_SYM(IDLE), .SYNC_COUNT(4)) dut0 (.clk_32f(clk_32f), .reset(reset), .bus(b0));
    paralelo_serial_tx #(.IDLE_SYM(IDLE), .SYNC_COUNT(1)) dut1 (.clk_32f(clk_32f), .reset(reset), .bus(b1));
    int checks = 0;
    int passed = 0;
    int pct = 0;
    int sc[2] = '{4, 1};
    int n[2];
    logic [7:0] cur[2], pend[2], s_data[2];
    bit cur_d[2], pend_v[2], m_act[2], s_valid[2];
    assign b0.data_in  = s_data[0];
    assign b0.valid_in = s_valid[0];
    assign b1.data_in  = s_data[1];
    assign b1.valid_in = s_valid[1];
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask
    function automatic bit m_ready(input int i);
        return m_act[i] && !pend_v[i];
    endfunction
    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            n[i] = 0; cur[i] = '0; cur_d[i] = 0; pend_v[i] = 0; m_act[i] = 0;
        end
    endfunction
    // expected line state: byte k starts at edge 8k+1, bit 7 first
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic e_do;
            e_do = (n[i] == 0) ? 1'b0 : cur[i][7 - ((n[i] - 1) % 8)];
            chk($sformatf("data_out%0d", i), 8'(i ? b1.data_out : b0.data_out), 8'(e_do));
            chk($sformatf("byte_start%0d", i), 8'(i ? b1.byte_start : b0.byte_start), 8'(n[i] > 0 && (n[i] - 1) % 8 == 0));
            chk($sformatf("data_valid%0d", i), 8'(i ? b1.data_valid_out : b0.data_valid_out), 8'(n[i] > 0 && cur_d[i]));
            chk($sformatf("active%0d", i), 8'(i ? b1.active : b0.active), 8'(m_act[i]));
            chk($sformatf("ready%0d", i), 8'(i ? b1.ready_out : b0.ready_out), 8'(m_ready(i)));
        end
    endtask
    task automatic step();
        bit acc[2];
        for (int i = 0; i < 2; i++) acc[i] = s_valid[i] && m_ready(i);
        @(posedge clk_32f);
        for (int i = 0; i < 2; i++) begin
            n[i]++;
            if ((n[i] - 1) % 8 == 0) begin
                if (m_act[i] && pend_v[i]) begin
                    cur[i] = pend[i]; cur_d[i] = 1; pend_v[i] = 0;
                end else begin
                    cur[i] = IDLE; cur_d[i] = 0;
                end
            end
            if (n[i] == 8 * (sc[i] - 1) + 1) m_act[i] = 1;
            if (acc[i]) begin
                pend[i] = s_data[i]; pend_v[i] = 1;
            end
        end
        @(negedge clk_32f);
        check_all();
        for (int i = 0; i < 2; i++)
            if (acc[i] || !s_valid[i]) begin
                s_valid[i] = $urandom_range(0, 99) < pct;
                s_data[i]  = 8'($urandom);
            end
    endtask
    // reset lands mid-cycle so outputs must clear with no clock edge
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk_32f);
        @(negedge clk_32f);
        check_all();
        reset = 1'b0;
    endtask
    initial begin
        s_valid = '{0, 0};
        s_data  = '{8'h00, 8'h00};
        model_reset();
        repeat (2) @(negedge clk_32f);
        check_all();
        reset = 1'b0;
        pct = 0;
        repeat (80) step();
        pct = 100;
        repeat (200) step();
        pct = 30;
        repeat (300) step();
        for (int r = 0; r < 8; r++) begin
            pct = $urandom_range(20, 100);
            repeat ($urandom_range(30, 150)) step();
            do_reset();
        end
        pct = 60;
        repeat (120) step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
